load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into single-beat bus transactions,
// handling byte/half/word lanes, misalignment rejection and bus timeouts.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_mem_acc_mode,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_bus_err;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;

    logic        w_req;
    logic [1:0]  w_size;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Size code: 0 = byte, 1 = half, 2 = word; mode[1:0]=11 behaves as word.
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign w_req = i_rd_en | i_wr_en;

    // Access size decode and alignment check
    always_comb begin
        case (i_mem_acc_mode[1:0])
            2'b00:   w_size = 2'd0;
            2'b01:   w_size = 2'd1;
            default: w_size = 2'd2;
        endcase
        case (w_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~i_addr[0];
            default: w_aligned = (i_addr[1:0] == 2'b00);
        endcase
    end

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        case (w_size)
            2'd0: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    assign o_stall    = (r_state == S_BUSY) | ((r_state == S_IDLE) & w_req & w_aligned);
    assign o_misalign = (r_state == S_IDLE) & w_req & ~w_aligned & ~i_rst;

    // Transaction FSM with registered bus and result outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_offset    <= 2'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rdata   <= 32'd0;
                    r_bus_err <= 1'b0;
                    if (w_req && w_aligned) begin
                        r_state     <= S_BUSY;
                        r_wait_cnt  <= 8'd0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_wr_en;
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_wdata <= i_wr_en ? w_wdata : 32'd0;
                        r_bus_be    <= i_wr_en ? w_be : 4'd0;
                        r_offset    <= i_addr[1:0];
                        r_size      <= w_size;
                        r_unsigned  <= i_mem_acc_mode[2];
                    end
                end
                S_BUSY: begin
                    if (i_bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_rdata   <= r_bus_we ? 32'd0
                                              : f_extract(i_bus_rdata, r_offset, r_size, r_unsigned);
                    end else if (r_wait_cnt == LP_LAST) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_rdata   <= 32'd0;
                    r_bus_err <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_bus_err   = r_bus_err;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard-driven bench for load_store_unit: expected transactions are queued
// when a request is driven and compared when the unit completes it.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_rd_en = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [2:0]  i_mem_acc_mode = 3'd0;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_misalign;
    logic        o_bus_err;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;

    load_store_unit #(.TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_mem_acc_mode(i_mem_acc_mode),
        .o_rdata(o_rdata), .o_stall(o_stall), .o_misalign(o_misalign),
        .o_bus_err(o_bus_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        int          reqs;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] ob_rdata, ob_addr, ob_wdata, ob_after_rdata;
    logic [3:0]  ob_be;
    logic        ob_err, ob_we, ob_mis, ob_mis2, ob_txn, ob_stable;
    logic        ob_done_stall, ob_after_req, ob_after_err;
    int          ob_stall, ob_reqs;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] m);
        logic [31:0] s;
        s = w >> (8 * off);
        case (m)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives one request at posedge+1, answers the bus after 'waits' cycles (-1: never)
    // and records what the unit did; ends at posedge+1 of the cycle after completion.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] m, input int waits,
                         input logic [31:0] rw);
        int  w;
        logic fin;
        i_rd_en = rd; i_wr_en = wr; i_addr = a; i_wdata = wd; i_mem_acc_mode = m;
        #1;
        ob_stall = o_stall ? 1 : 0;
        ob_mis = o_misalign;
        ob_reqs = 0; ob_stable = 1'b1; fin = 1'b0;
        if (!o_stall) begin
            i_rd_en = 1'b0; i_wr_en = 1'b0;
            @(posedge i_clk); #1;
            ob_mis2 = o_misalign; ob_txn = o_bus_req; ob_rdata = o_rdata; ob_err = o_bus_err;
            return;
        end
        @(posedge i_clk); #1;
        ob_txn = o_bus_req; ob_mis2 = o_misalign;
        ob_we = o_bus_we; ob_addr = o_bus_addr; ob_be = o_bus_be; ob_wdata = o_bus_wdata;
        w = 0;
        while (!fin && w < 300) begin
            if (!o_bus_req) begin
                fin = 1'b1;
            end else begin
                ob_stall += o_stall ? 1 : 0;
                ob_reqs++;
                if (o_bus_we !== ob_we || o_bus_addr !== ob_addr || o_bus_be !== ob_be ||
                    o_bus_wdata !== ob_wdata) ob_stable = 1'b0;
                i_bus_ack = (waits >= 0 && w == waits);
                i_bus_rdata = i_bus_ack ? rw : ~rw;
                @(posedge i_clk); #1;
                i_bus_ack = 1'b0;
                w++;
            end
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL issue_bound: no completion after %0d cycles, required completion", w);
        end
        ob_done_stall = o_stall; ob_rdata = o_rdata; ob_err = o_bus_err;
        i_rd_en = 1'b0; i_wr_en = 1'b0;
        @(posedge i_clk); #1;
        ob_after_req = o_bus_req; ob_after_rdata = o_rdata; ob_after_err = o_bus_err;
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b1;
        #1;
        n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %b want 0", o_bus_req); end
        n_checks++; if (o_bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we: got %b want 0", o_bus_we); end
        n_checks++; if (o_bus_addr !== 32'd0) begin n_fail++; $display("FAIL rst_bus_addr: got %h want 0", o_bus_addr); end
        n_checks++; if (o_bus_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_bus_wdata: got %h want 0", o_bus_wdata); end
        n_checks++; if (o_bus_be !== 4'd0) begin n_fail++; $display("FAIL rst_bus_be: got %b want 0", o_bus_be); end
        n_checks++; if (o_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", o_rdata); end
        n_checks++; if (o_misalign !== 1'b0 || o_bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got mis=%b err=%b want 0 0", o_misalign, o_bus_err); end
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", o_stall); end
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_lb();
        exp_t e;
        exp_q.push_back('{32'hFFFF_FF80, 1'b0, 1'b0, 32'h100, 4'b0000, 32'd0, 2, 1});
        issue(1'b1, 1'b0, 32'h103, 32'd0, 3'b000, 0, 32'h80FF_1234);
        e = exp_q.pop_front();
        n_checks++; if (ob_addr !== e.addr) begin n_fail++; $display("FAIL lb_addr: got %h want %h", ob_addr, e.addr); end
        n_checks++; if (ob_be !== e.be || ob_we !== e.we) begin n_fail++; $display("FAIL lb_be_we: got %b/%b want %b/%b", ob_be, ob_we, e.be, e.we); end
        n_checks++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want %0d", ob_stall, e.stall); end
        n_checks++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lb_rdata: got %h want %h", ob_rdata, e.rdata); end
        n_checks++; if (ob_done_stall !== 1'b0 || ob_err !== 1'b0) begin n_fail++; $display("FAIL lb_done: got stall=%b err=%b want 0 0", ob_done_stall, ob_err); end
    endtask

    task automatic test_sh_wait();
        exp_t e;
        exp_q.push_back('{32'd0, 1'b0, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 5, 4});
        issue(1'b0, 1'b1, 32'h202, 32'hDEAD_BEEF, 3'b001, 3, 32'h0);
        e = exp_q.pop_front();
        n_checks++; if (ob_we !== e.we || ob_be !== e.be) begin n_fail++; $display("FAIL sh_we_be: got %b/%b want %b/%b", ob_we, ob_be, e.we, e.be); end
        n_checks++; if (ob_wdata !== e.wdata) begin n_fail++; $display("FAIL sh_wdata: got %h want %h", ob_wdata, e.wdata); end
        n_checks++; if (ob_stable !== 1'b1) begin n_fail++; $display("FAIL sh_stable: got %b want 1", ob_stable); end
        n_checks++; if (ob_reqs != e.reqs || ob_stall != e.stall) begin n_fail++; $display("FAIL sh_latency: got req=%0d stall=%0d want %0d %0d", ob_reqs, ob_stall, e.reqs, e.stall); end
        n_checks++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL sh_rdata: got %h want %h", ob_rdata, e.rdata); end
    endtask

    task automatic test_misalign();
        logic [31:0] addrs [3];
        logic [2:0]  modes [3];
        logic        wrs   [3];
        addrs = '{32'h006, 32'h003, 32'h102};
        modes = '{3'b010, 3'b101, 3'b010};
        wrs   = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            issue(~wrs[k], wrs[k], addrs[k], 32'h1234_5678, modes[k], 0, 32'h0);
            n_checks++; if (ob_mis !== 1'b1 || ob_stall != 0) begin n_fail++; $display("FAIL mis_pulse_%0d: got mis=%b stall=%0d want 1 0", k, ob_mis, ob_stall); end
            n_checks++; if (ob_mis2 !== 1'b0 || ob_txn !== 1'b0) begin n_fail++; $display("FAIL mis_after_%0d: got mis=%b req=%b want 0 0", k, ob_mis2, ob_txn); end
            n_checks++; if (ob_rdata !== 32'd0) begin n_fail++; $display("FAIL mis_rdata_%0d: got %h want 0", k, ob_rdata); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        exp_q.push_back('{32'd0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'd0, 17, 16});
        issue(1'b1, 1'b0, 32'h10, 32'd0, 3'b101, -1, 32'h5555_AAAA);
        e = exp_q.pop_front();
        n_checks++; if (ob_reqs != e.reqs) begin n_fail++; $display("FAIL to_req_cycles: got %0d want %0d", ob_reqs, e.reqs); end
        n_checks++; if (ob_err !== e.err || ob_rdata !== e.rdata) begin n_fail++; $display("FAIL to_done: got err=%b rdata=%h want %b %h", ob_err, ob_rdata, e.err, e.rdata); end
        n_checks++; if (ob_after_req !== 1'b0 || ob_after_err !== 1'b0) begin n_fail++; $display("FAIL to_idle: got req=%b err=%b want 0 0", ob_after_req, ob_after_err); end
        // Ack on the final allowed wait cycle must still complete as a normal load.
        exp_q.push_back('{32'h0000_1234, 1'b0, 1'b0, 32'h10, 4'b0000, 32'd0, 17, 16});
        issue(1'b1, 1'b0, 32'h12, 32'd0, 3'b101, 15, 32'h1234_ABCD);
        e = exp_q.pop_front();
        n_checks++; if (ob_err !== e.err || ob_rdata !== e.rdata) begin n_fail++; $display("FAIL to_last_ack: got err=%b rdata=%h want %b %h", ob_err, ob_rdata, e.err, e.rdata); end
        n_checks++; if (ob_reqs != e.reqs) begin n_fail++; $display("FAIL to_last_req: got %0d want %0d", ob_reqs, e.reqs); end
    endtask

    task automatic test_reset_mid_busy();
        i_rd_en = 1'b1; i_addr = 32'h20; i_mem_acc_mode = 3'b010;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL rb_busy: got req=%b want 1", o_bus_req); end
        #2 i_rst = 1'b1;
        #1;
        n_checks++; if (o_bus_req !== 1'b0 || o_bus_err !== 1'b0) begin n_fail++; $display("FAIL rb_async: got req=%b err=%b want 0 0", o_bus_req, o_bus_err); end
        i_rd_en = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(posedge i_clk); #1;
        i_bus_ack = 1'b0;
        n_checks++; if (o_bus_req !== 1'b0 || o_bus_err !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL rb_late_ack: got req=%b err=%b stall=%b want 0 0 0", o_bus_req, o_bus_err, o_stall); end
        @(posedge i_clk); #1;
        n_checks++; if (o_rdata !== 32'd0 || o_bus_err !== 1'b0) begin n_fail++; $display("FAIL rb_rdata: got rdata=%h err=%b want 0 0", o_rdata, o_bus_err); end
    endtask

    task automatic test_both_en();
        exp_t e;
        exp_q.push_back('{32'd0, 1'b0, 1'b1, 32'h0, 4'b0010, 32'hABAB_ABAB, 2, 1});
        issue(1'b1, 1'b1, 32'h1, 32'h0000_00AB, 3'b000, 0, 32'h7777_7777);
        e = exp_q.pop_front();
        n_checks++; if (ob_we !== e.we || ob_be !== e.be) begin n_fail++; $display("FAIL both_we_be: got %b/%b want %b/%b", ob_we, ob_be, e.we, e.be); end
        n_checks++; if (ob_wdata !== e.wdata || ob_addr !== e.addr) begin n_fail++; $display("FAIL both_data: got %h@%h want %h@%h", ob_wdata, ob_addr, e.wdata, e.addr); end
        n_checks++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL both_rdata: got %h want %h", ob_rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [8];
        logic [2:0]  modes [8];
        logic        wrs   [8];
        logic [31:0] words [8];
        logic [31:0] wds   [8];
        exp_t e;
        addrs = '{32'h102, 32'h101, 32'h100, 32'h104, 32'h100, 32'h108, 32'h300, 32'h303};
        modes = '{3'b001, 3'b100, 3'b000, 3'b010, 3'b101, 3'b011, 3'b010, 3'b100};
        wrs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        words = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h1357_9BDF,
                  32'h8001_7FFF, 32'hCAFE_F00D, 32'h0, 32'h0};
        wds   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1122_3344, 32'h0000_005A};
        for (int k = 0; k < 8; k++) begin
            e.addr = addrs[k] & 32'hFFFF_FFFC;
            e.we = wrs[k];
            e.err = 1'b0;
            e.stall = 2 + (k % 3);
            e.reqs = 1 + (k % 3);
            if (wrs[k]) begin
                e.rdata = 32'd0;
                case (modes[k][1:0])
                    2'b00: begin e.be = 4'b0001 << addrs[k][1:0]; e.wdata = {4{wds[k][7:0]}}; end
                    2'b01: begin e.be = addrs[k][1] ? 4'b1100 : 4'b0011; e.wdata = {2{wds[k][15:0]}}; end
                    default: begin e.be = 4'b1111; e.wdata = wds[k]; end
                endcase
            end else begin
                e.rdata = model_load(words[k], addrs[k][1:0], modes[k]);
                e.be = 4'b0000;
                e.wdata = 32'd0;
            end
            exp_q.push_back(e);
            issue(~wrs[k], wrs[k], addrs[k], wds[k], modes[k], k % 3, words[k]);
            e = exp_q.pop_front();
            n_checks++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h want %h", k, ob_rdata, e.rdata); end
            n_checks++; if (ob_be !== e.be || ob_wdata !== e.wdata || ob_addr !== e.addr || ob_we !== e.we) begin
                n_fail++; $display("FAIL b2b_bus_%0d: got we=%b be=%b %h@%h want we=%b be=%b %h@%h",
                                   k, ob_we, ob_be, ob_wdata, ob_addr, e.we, e.be, e.wdata, e.addr);
            end
            n_checks++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL b2b_stall_%0d: got %0d want %0d", k, ob_stall, e.stall); end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh_wait();
        test_misalign();
        test_timeout();
        test_reset_mid_busy();
        test_both_en();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
